seq_ram_arbiter: RTL

Arbitrates single-port access to the 32-entry sequence RAM between three requesters: the sequence generator (writes), the playback engine (reads, drives the display), and the input checker (reads, compares player input). It sits between those blocks and the RAM macro and owns the RAM address, data and write-enable pins. The RAM has one cycle of registered read latency.

---
 rtl/seq_arb_pkg.sv | 7 +
 rtl/seq_arb_pick.sv | 21 ++
 rtl/seq_ram_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/seq_arb_pkg.sv
// seq_arb_pkg: shared widths, FSM states and requester ids for the sequence RAM arbiter
package seq_arb_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
  typedef enum logic [1:0] {REQ_GEN, REQ_PLAY, REQ_CHK} req_id_t;
endpackage

// File: rtl/seq_arb_pick.sv
// seq_arb_pick: combinational winner select, gen first; SEQ_ARB_RR_EN makes play/chk round-robin
module seq_arb_pick
  import seq_arb_pkg::*;
(
  input  logic    gen_req,
  input  logic    play_req,
  input  logic    chk_req,
`ifdef SEQ_ARB_RR_EN
  input  logic    rr_chk,
`endif
  output req_id_t id,
  output logic    valid
);
  assign valid = gen_req | play_req | chk_req;
`ifdef SEQ_ARB_RR_EN
  // rr_chk set means the checker is preferred when both readers ask
  assign id = gen_req ? REQ_GEN : (chk_req && (rr_chk || !play_req)) ? REQ_CHK : REQ_PLAY;
`else
  assign id = gen_req ? REQ_GEN : play_req ? REQ_PLAY : REQ_CHK;
`endif
endmodule

// File: rtl/seq_ram_arbiter.sv
// seq_ram_arbiter: single-port sequence RAM arbiter for gen/play/chk (SEQ_ARB_RR_EN: round-robin readers)
module seq_ram_arbiter
  import seq_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              gen_req,
  input  logic [ADDR_W-1:0] gen_addr,
  input  logic [DATA_W-1:0] gen_wdata,
  output logic              gen_gnt,
  input  logic              play_req,
  input  logic [ADDR_W-1:0] play_addr,
  output logic              play_gnt,
  output logic              play_rvalid,
  input  logic              chk_req,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_gnt,
  output logic              chk_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);
  state_t            state, state_nxt;
  req_id_t           pick_id, id;
  logic              pick_vld, win, is_wr;
  logic [ADDR_W-1:0] pick_addr, lat_addr;
  logic [DATA_W-1:0] lat_wdata, rdata_q;
`ifdef SEQ_ARB_RR_EN
  logic              rr_chk;
`endif
  seq_arb_pick u_pick (
    .gen_req  (gen_req),
    .play_req (play_req),
    .chk_req  (chk_req),
`ifdef SEQ_ARB_RR_EN
    .rr_chk   (rr_chk),
`endif
    .id       (pick_id),
    .valid    (pick_vld)
  );
  assign win       = state == IDLE && pick_vld;
  assign is_wr     = id == REQ_GEN;
  assign pick_addr = pick_id == REQ_GEN ? gen_addr : pick_id == REQ_PLAY ? play_addr : chk_addr;
  assign busy      = state != IDLE;
  // RAM output lands in the rvalid cycle, so it is passed straight through then and held afterwards
  assign rdata     = (play_rvalid || chk_rvalid) ? ram_q : rdata_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE ? (pick_vld ? ISSUE : IDLE) : (state == ISSUE && !is_wr) ? CAPTURE : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id          <= REQ_GEN;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      gen_gnt     <= 1'b0;
      play_gnt    <= 1'b0;
      chk_gnt     <= 1'b0;
      play_rvalid <= 1'b0;
      chk_rvalid  <= 1'b0;
      ram_wren    <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      rdata_q     <= '0;
    end else begin
      if (win) begin
        id        <= pick_id;
        lat_addr  <= pick_addr;
        lat_wdata <= gen_wdata;
      end
      gen_gnt     <= win && pick_id == REQ_GEN;
      play_gnt    <= win && pick_id == REQ_PLAY;
      chk_gnt     <= win && pick_id == REQ_CHK;
      ram_wren    <= state == ISSUE && is_wr;
      if (state == ISSUE) ram_addr <= lat_addr;
      if (state == ISSUE && is_wr) ram_wdata <= lat_wdata;
      play_rvalid <= state == CAPTURE && id == REQ_PLAY;
      chk_rvalid  <= state == CAPTURE && id == REQ_CHK;
      if (play_rvalid || chk_rvalid) rdata_q <= ram_q;
    end
  end
`ifdef SEQ_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_chk <= 1'b0;
    else if (win && pick_id != REQ_GEN) rr_chk <= pick_id == REQ_PLAY;
  end
`endif
endmodule
